// File: rtl/neo_pkg.sv
// Shared types and default widths for the NEO spike detection path.
// State encoding for the detector FSM and the spike record layout at default widths.
package neo_pkg;

  localparam int NEO_N     = 16;
  localparam int NEO_IDX_W = 16;

  typedef enum logic [1:0] {
    S_WARMUP,
    S_ARMED,
    S_TRACK,
    S_REFRACT
  } det_state_t;

  typedef struct packed {
    logic [NEO_IDX_W-1:0] index;
    logic [NEO_N-1:0]     peak;
  } spike_rec_t;

endpackage

// File: rtl/neo_ema_threshold.sv
// Warm-up mean, EMA of |energy| and threshold = avg * K_MULT.
// Latency: avg updates on the sample edge, threshold one cycle later; no backpressure.
module neo_ema_threshold
  import neo_pkg::*;
#(
  parameter int N           = NEO_N,
  parameter int ALPHA_SHIFT = 4,
  parameter int K_MULT      = 4,
  parameter int K_W         = 4,
  parameter int WARMUP      = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [N-1:0]     mag,
  input  logic             acc_en,
  input  logic             acc_last,
  input  logic             ema_en,
  output logic [N+K_W-1:0] threshold
);

  localparam int WL = $clog2(WARMUP);
  localparam int AW = N + WL;

  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_sum;
  logic [N-1:0]       avg;
  logic signed [N+1:0] diff;
  logic signed [N+1:0] step;
  logic signed [N+1:0] ema;
  logic [N-1:0]       ema_clamped;

  // Two guard bits keep mag-avg and avg+step exact before clamping.
  always_comb begin
    acc_sum = acc + AW'(mag);
    diff    = $signed({2'b00, mag}) - $signed({2'b00, avg});
    step    = diff >>> ALPHA_SHIFT;
    ema     = $signed({2'b00, avg}) + step;
    if (ema[N+1]) begin
      ema_clamped = '0;
    end else if (ema[N]) begin
      ema_clamped = '1;
    end else begin
      ema_clamped = ema[N-1:0];
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      avg       <= '0;
      threshold <= '0;
    end else begin
      threshold <= {{K_W{1'b0}}, avg} * (N+K_W)'(K_MULT);
      if (acc_en) begin
        if (acc_last) begin
          avg <= acc_sum[WL +: N];
          acc <= '0;
        end else begin
          acc <= acc_sum;
        end
      end else if (ema_en) begin
        avg <= ema_clamped;
      end
    end
  end

endmodule

// File: rtl/neo_spike_detector.sv
// Adaptive-threshold spike detector on the NEO stream; one record per event with peak and index.
// Latency: spike_valid on the edge sampling the closing beat; no backpressure (every valid beat consumed).
module neo_spike_detector
  import neo_pkg::*;
#(
  parameter int N           = NEO_N,
  parameter int ALPHA_SHIFT = 4,
  parameter int K_MULT      = 4,
  parameter int K_W         = 4,
  parameter int WARMUP      = 16,
  parameter int MAX_LEN     = 8,
  parameter int REFRACT     = 10,
  parameter int IDX_W       = NEO_IDX_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             neo_valid,
  input  logic [N-1:0]     neo_data,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_index,
  output logic [N-1:0]     spike_peak,
  output logic [N+K_W-1:0] threshold,
  output logic             armed
);

  localparam int WC_W  = $clog2(WARMUP) + 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int RC_W  = $clog2(REFRACT + 2);

  det_state_t       state;
  logic [WC_W-1:0]  warm_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] peak_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [LEN_W-1:0] len;
  logic [RC_W-1:0]  rcnt;
  logic [N-1:0]     mag;
  logic [N-1:0]     peak;
  logic [N-1:0]     cand_peak;
  logic             above;
  logic             warm_last;
  logic             close_evt;
  logic             acc_en;
  logic             ema_en;

  always_comb begin
    mag       = neo_data[N-1] ? (~neo_data + N'(1)) : neo_data;
    above     = {{K_W{1'b0}}, mag} > threshold;
    warm_last = warm_cnt == WC_W'(WARMUP - 1);
    // Strict compare so ties keep the earlier peak.
    cand_peak = (mag > peak) ? mag : peak;
    cand_idx  = (mag > peak) ? idx : peak_idx;
    close_evt = !above || (len == LEN_W'(MAX_LEN));
    acc_en    = neo_valid && (state == S_WARMUP);
    ema_en    = neo_valid && (((state == S_ARMED) && !above) || (state == S_REFRACT));
  end

  neo_ema_threshold #(
    .N           (N),
    .ALPHA_SHIFT (ALPHA_SHIFT),
    .K_MULT      (K_MULT),
    .K_W         (K_W),
    .WARMUP      (WARMUP)
  ) u_ema (
    .Clk       (Clk),
    .reset     (reset),
    .mag       (mag),
    .acc_en    (acc_en),
    .acc_last  (warm_last),
    .ema_en    (ema_en),
    .threshold (threshold)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= S_WARMUP;
      warm_cnt    <= '0;
      idx         <= '0;
      len         <= '0;
      rcnt        <= '0;
      peak        <= '0;
      peak_idx    <= '0;
      spike_valid <= 1'b0;
      spike_index <= '0;
      spike_peak  <= '0;
      armed       <= 1'b0;
    end else begin
      spike_valid <= 1'b0;
      if (neo_valid) begin
        idx <= idx + IDX_W'(1);
        case (state)
          S_WARMUP: begin
            if (warm_last) begin
              state    <= S_ARMED;
              armed    <= 1'b1;
              warm_cnt <= '0;
            end else begin
              warm_cnt <= warm_cnt + WC_W'(1);
            end
          end
          S_ARMED: begin
            if (above) begin
              state    <= S_TRACK;
              armed    <= 1'b0;
              peak     <= mag;
              peak_idx <= idx;
              len      <= LEN_W'(1);
            end
          end
          S_TRACK: begin
            peak     <= cand_peak;
            peak_idx <= cand_idx;
            if (close_evt) begin
              spike_valid <= 1'b1;
              spike_index <= cand_idx;
              spike_peak  <= cand_peak;
              len         <= '0;
              if (REFRACT == 0) begin
                state <= S_ARMED;
                armed <= 1'b1;
              end else begin
                state <= S_REFRACT;
                rcnt  <= RC_W'(REFRACT);
              end
            end else begin
              len <= len + LEN_W'(1);
            end
          end
          S_REFRACT: begin
            rcnt <= rcnt - RC_W'(1);
            if (rcnt == RC_W'(1)) begin
              state <= S_ARMED;
              armed <= 1'b1;
            end
          end
          default: begin
            state <= S_WARMUP;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neo_spike_detector.sv
// Bench for neo_spike_detector: directed pins plus randomized stream against a sample-level model.
`timescale 1ns/1ps
module tb_neo_spike_detector;
  localparam int N = 16, K_W = 4, IDX_W = 16;
  localparam int K = 4, ASH = 4, WU = 16, MAXL = 8, RF = 10;

  logic             Clk = 1'b0;
  logic             reset = 1'b1;
  logic             neo_valid = 1'b0;
  logic [N-1:0]     neo_data = '0;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_index;
  logic [N-1:0]     spike_peak;
  logic [N+K_W-1:0] threshold;
  logic             armed;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  neo_spike_detector #(
    .N(N), .ALPHA_SHIFT(ASH), .K_MULT(K), .K_W(K_W), .WARMUP(WU),
    .MAX_LEN(MAXL), .REFRACT(RF), .IDX_W(IDX_W)
  ) dut (
    .Clk(Clk), .reset(reset), .neo_valid(neo_valid), .neo_data(neo_data),
    .spike_valid(spike_valid), .spike_index(spike_index), .spike_peak(spike_peak),
    .threshold(threshold), .armed(armed)
  );

  // Sample-level model: integers and counters straight from the behavioural rules.
  int m_warm, m_acc, m_avg, m_thr, m_idx, m_len, m_peak, m_pidx, m_ref;
  int m_sv, m_sidx, m_speak;
  bit m_in_evt;

  function automatic int ema(input int avg, input int x);
    int d, st, r;
    d = x - avg;
    if (d >= 0) st = d / (2**ASH);
    else        st = -((-d + 2**ASH - 1) / (2**ASH));
    r = avg + st;
    if (r < 0) r = 0;
    if (r > 2**N - 1) r = 2**N - 1;
    return r;
  endfunction

  always @(posedge Clk or posedge reset) begin : model
    int mag, old_avg;
    if (reset) begin
      m_warm = 0; m_acc = 0; m_avg = 0; m_thr = 0; m_idx = 0; m_len = 0;
      m_peak = 0; m_pidx = 0; m_ref = 0; m_sv = 0; m_sidx = 0; m_speak = 0;
      m_in_evt = 0;
    end else begin
      old_avg = m_avg;
      m_sv = 0;
      if (neo_valid) begin
        mag = $signed(neo_data);
        if (mag < 0) mag = -mag;
        if (m_warm < WU) begin
          m_acc += mag;
          m_warm++;
          if (m_warm == WU) m_avg = m_acc / WU;
        end else if (m_in_evt) begin
          if (mag > m_peak) begin
            m_peak = mag;
            m_pidx = m_idx;
          end
          if (mag <= m_thr || m_len == MAXL) begin
            m_sv = 1; m_sidx = m_pidx; m_speak = m_peak;
            m_in_evt = 0; m_ref = RF;
          end else begin
            m_len++;
          end
        end else if (m_ref > 0) begin
          m_ref--;
          m_avg = ema(m_avg, mag);
        end else if (mag > m_thr) begin
          m_in_evt = 1; m_peak = mag; m_pidx = m_idx; m_len = 1;
        end else begin
          m_avg = ema(m_avg, mag);
        end
        m_idx = (m_idx + 1) % (2**IDX_W);
      end
      m_thr = old_avg * K;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!reset) begin
      chk("spike_valid", 64'(spike_valid), 64'(m_sv));
      chk("spike_index", 64'(spike_index), 64'(m_sidx));
      chk("spike_peak",  64'(spike_peak),  64'(m_speak));
      chk("threshold",   64'(threshold),   64'(m_thr));
      chk("armed",       64'(armed), 64'((m_warm == WU) && !m_in_evt && (m_ref == 0)));
    end
  end

  // One valid beat; returns at the negedge right after the sampling edge.
  task automatic beat(input int v, input int gap);
    @(negedge Clk);
    neo_valid = 1'b1;
    neo_data  = v[N-1:0];
    @(negedge Clk);
    neo_valid = 1'b0;
    neo_data  = N'($urandom);
    repeat (gap) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset = 1'b1;
    #1;
    chk("rst_spike_valid", 64'(spike_valid), 64'd0);
    chk("rst_threshold",   64'(threshold),   64'd0);
    chk("rst_armed",       64'(armed),       64'd0);
    chk("rst_spike_index", 64'(spike_index), 64'd0);
    chk("rst_spike_peak",  64'(spike_peak),  64'd0);
    repeat (2) @(negedge Clk);
    reset = 1'b0;
  endtask

  initial begin
    int v, prev;
    repeat (3) @(negedge Clk);
    do_reset();

    for (int i = 0; i < WU; i++) begin
      beat(100, 0);
      if (i == WU - 2) chk("armed_before_last_warm", 64'(armed), 64'd0);
    end
    chk("armed_after_warm", 64'(armed), 64'd1);
    chk("thr_lags_avg", 64'(threshold), 64'd0);
    @(negedge Clk);
    chk("thr_after_warm", 64'(threshold), 64'd400);

    beat(100, 0); beat(500, 0); beat(900, 0); beat(700, 0);
    chk("no_spike_in_event", 64'(spike_valid), 64'd0);
    beat(100, 0);
    chk("basic_spike_valid", 64'(spike_valid), 64'd1);
    chk("basic_spike_index", 64'(spike_index), 64'd18);
    chk("basic_spike_peak",  64'(spike_peak),  64'd900);
    @(negedge Clk);
    chk("spike_one_cycle", 64'(spike_valid), 64'd0);
    chk("avg_frozen_in_track", 64'(threshold), 64'd400);

    for (int i = 0; i < RF; i++) begin
      beat(100, 0);
      if (i == RF - 2) chk("refract_not_armed", 64'(armed), 64'd0);
    end
    chk("armed_after_refract", 64'(armed), 64'd1);

    beat(116, 5);
    chk("ema_up_thr", 64'(threshold), 64'd404);
    beat(0, 1);
    chk("ema_down_thr", 64'(threshold), 64'd376);

    for (int i = 0; i < 9; i++) begin
      beat(1000, 0);
      if (i == 7) chk("maxlen_no_early_spike", 64'(spike_valid), 64'd0);
    end
    chk("maxlen_spike_valid", 64'(spike_valid), 64'd1);
    chk("maxlen_spike_index", 64'(spike_index), 64'd33);
    chk("maxlen_spike_peak",  64'(spike_peak),  64'd1000);

    for (int i = 0; i < RF; i++) beat(0, 0);
    beat(-32768, 0);
    beat(0, 0);
    chk("neg_full_scale_index", 64'(spike_index), 64'd52);
    chk("neg_full_scale_peak",  64'(spike_peak),  64'd32768);

    for (int i = 0; i < RF; i++) beat(0, 0);
    beat(900, 0);
    chk("track_entered", 64'(armed), 64'd0);
    do_reset();
    for (int i = 0; i < WU; i++) begin
      beat(1000, 0);
      if (i == WU - 2) chk("rewarm_not_armed", 64'(armed), 64'd0);
    end
    chk("rewarm_armed", 64'(armed), 64'd1);
    chk("rewarm_no_spike_kept", 64'(spike_peak), 64'd0);

    prev = 0;
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10)      v = prev;
      else if (r < 12) v = -32768;
      else if (r < 14) v = 32767;
      else if (r < 24) v = $urandom_range(3000, 32767);
      else             v = $urandom_range(0, 3000);
      if (r >= 14 && $urandom_range(0, 1) == 1) v = -v;
      prev = v;
      beat(v, $urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
